// File: rtl/param_sync_fifo.sv
// Single-clock circular FIFO. The occupancy counter drives all status flags, and depth may be any integer >= 2.
// Read data is registered; error flags are sticky.
module param_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              clr_err_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic rd_acc, wr_acc, ovf_evt, unf_evt;

    // Flags decode the registered count only.
    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (count_q <= CNT_W'(AE_THRESH));

    // Flush masks both requests, so nothing is accepted and no error is raised that cycle.
    assign rd_acc  = rd_en_i & ~empty_o & ~flush_i;
    assign wr_acc  = wr_en_i & (~full_o | rd_acc) & ~flush_i;
    assign ovf_evt = wr_en_i & ~wr_acc & ~flush_i;
    assign unf_evt = rd_en_i & empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // A new error event takes precedence over a simultaneous clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end
        if (unf_evt) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Storage has no reset. When the FIFO is full, a read and a write to the same slot return the old word.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo. Instance A uses depth 16 and instance B uses depth 10 to exercise non-power-of-2 wrap.
// Expected values are written by hand at each step.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: DEPTH=16, AF=14, AE=2
    logic       a_rst_n, a_flush, a_clr, a_wr, a_rd;
    logic [7:0] a_wdata, a_rdata;
    logic       a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_count;

    param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) u_a (
        .clk(clk), .rst_n(a_rst_n), .flush_i(a_flush), .clr_err_i(a_clr),
        .wr_en_i(a_wr), .wr_data_i(a_wdata), .rd_en_i(a_rd),
        .rd_data_o(a_rdata), .rd_valid_o(a_rvalid), .full_o(a_full), .empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .count_o(a_count),
        .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    // Instance B: DEPTH=10
    logic       b_rst_n, b_flush, b_clr, b_wr, b_rd;
    logic [7:0] b_wdata, b_rdata;
    logic       b_rvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [3:0] b_count;

    param_sync_fifo #(.DATA_W(8), .DEPTH(10)) u_b (
        .clk(clk), .rst_n(b_rst_n), .flush_i(b_flush), .clr_err_i(b_clr),
        .wr_en_i(b_wr), .wr_data_i(b_wdata), .rd_en_i(b_rd),
        .rd_data_o(b_rdata), .rd_valid_o(b_rvalid), .full_o(b_full), .empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .count_o(b_count),
        .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, ".count"}, 32'(a_count), 0);
        check({tag, ".empty"}, 32'(a_empty), 1);
        check({tag, ".full"}, 32'(a_full), 0);
        check({tag, ".ae"}, 32'(a_ae), 1);
        check({tag, ".af"}, 32'(a_af), 0);
        check({tag, ".rdata"}, 32'(a_rdata), 0);
        check({tag, ".rvalid"}, 32'(a_rvalid), 0);
        check({tag, ".ovf"}, 32'(a_ovf), 0);
        check({tag, ".unf"}, 32'(a_unf), 0);
        $display("txn %s: count=%0d empty=%0d rdata=0x%02h", tag, a_count, a_empty, a_rdata);
    endtask

    initial begin
        a_rst_n = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0;
        tick();
        check_a_reset("reset");
        check("b_reset.count", 32'(b_count), 0);
        check("b_reset.empty", 32'(b_empty), 1);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Fill A with 0x00..0x0F.
        a_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_wdata = 8'(i);
            tick();
            check("fill.count", 32'(a_count), 32'(i + 1));
            check("fill.af", 32'(a_af), (i + 1 >= 14) ? 1 : 0);
            check("fill.full", 32'(a_full), (i + 1 == 16) ? 1 : 0);
            $display("txn write 0x%02h: count=%0d af=%0d full=%0d", a_wdata, a_count, a_af, a_full);
        end
        a_wdata = 8'hAA;
        tick();
        check("ovf_write.ovf", 32'(a_ovf), 1);
        check("ovf_write.count", 32'(a_count), 16);
        $display("txn write 0xAA on full: ovf=%0d count=%0d", a_ovf, a_count);
        a_wr = 1'b0;

        // Drain in order.
        a_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain.rvalid", 32'(a_rvalid), 1);
            check("drain.rdata", 32'(a_rdata), 32'(i));
            $display("txn read: rdata=0x%02h rvalid=%0d count=%0d", a_rdata, a_rvalid, a_count);
        end
        check("drain.empty", 32'(a_empty), 1);
        tick();
        check("unf_read.unf", 32'(a_unf), 1);
        check("unf_read.rvalid", 32'(a_rvalid), 0);
        check("unf_read.rdata", 32'(a_rdata), 32'h0F);
        $display("txn read on empty: unf=%0d rvalid=%0d rdata=0x%02h", a_unf, a_rvalid, a_rdata);
        a_rd = 1'b0;

        a_clr = 1'b1;
        tick();
        check("clr1.ovf", 32'(a_ovf), 0);
        check("clr1.unf", 32'(a_unf), 0);
        $display("txn clr_err: ovf=%0d unf=%0d", a_ovf, a_unf);
        a_clr = 1'b0;

        // Fill with 0x40.., then stream 20 simultaneous write/read cycles while full.
        a_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_wdata = 8'(8'h40 + i);
            tick();
        end
        check("refill.full", 32'(a_full), 1);
        a_rd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_wdata = 8'(8'h80 + k);
            tick();
            check("stream.count", 32'(a_count), 16);
            check("stream.full", 32'(a_full), 1);
            check("stream.ovf", 32'(a_ovf), 0);
            check("stream.rvalid", 32'(a_rvalid), 1);
            check("stream.rdata", 32'(a_rdata), (k < 16) ? 32'(8'h40 + k) : 32'(8'h80 + k - 16));
            $display("txn stream wr=0x%02h rd=0x%02h count=%0d", a_wdata, a_rdata, a_count);
        end
        a_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("stream_drain.rdata", 32'(a_rdata), 32'(8'h84 + i));
            $display("txn read: rdata=0x%02h", a_rdata);
        end
        check("stream_drain.empty", 32'(a_empty), 1);

        // Simultaneous write/read on empty: only the write is accepted.
        a_wr = 1'b1;
        a_wdata = 8'h33;
        tick();
        check("empty_wr_rd.count", 32'(a_count), 1);
        check("empty_wr_rd.unf", 32'(a_unf), 1);
        check("empty_wr_rd.rvalid", 32'(a_rvalid), 0);
        $display("txn wr+rd on empty: count=%0d unf=%0d rvalid=%0d", a_count, a_unf, a_rvalid);
        a_wr = 1'b0;
        tick();
        check("read33.rdata", 32'(a_rdata), 32'h33);
        check("read33.rvalid", 32'(a_rvalid), 1);
        check("read33.count", 32'(a_count), 0);
        $display("txn read: rdata=0x%02h", a_rdata);
        a_rd = 1'b0;

        // Reach count=7 with overflow set, then flush with both requests active.
        a_wr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_wdata = 8'(8'h10 + i);
            tick();
        end
        check("pre_flush.ovf", 32'(a_ovf), 1);
        a_wr = 1'b0;
        a_rd = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("pre_flush.count", 32'(a_count), 7);
        check("pre_flush.rdata", 32'(a_rdata), 32'h18);
        a_flush = 1'b1;
        a_wr = 1'b1;
        a_wdata = 8'hEE;
        tick();
        check("flush.count", 32'(a_count), 0);
        check("flush.empty", 32'(a_empty), 1);
        check("flush.ovf", 32'(a_ovf), 1);
        check("flush.unf", 32'(a_unf), 1);
        check("flush.rvalid", 32'(a_rvalid), 0);
        check("flush.rdata", 32'(a_rdata), 32'h18);
        $display("txn flush: count=%0d ovf=%0d rdata=0x%02h", a_count, a_ovf, a_rdata);
        a_flush = 1'b0;
        a_wr = 1'b0;
        a_rd = 1'b0;
        tick();
        check("post_flush.count", 32'(a_count), 0);
        a_clr = 1'b1;
        tick();
        check("clr2.ovf", 32'(a_ovf), 0);
        $display("txn clr_err: ovf=%0d", a_ovf);
        a_clr = 1'b0;

        // Reset in the middle of a burst.
        a_wr = 1'b1;
        a_wdata = 8'h77;
        tick();
        a_rd = 1'b1;
        a_wdata = 8'h78;
        tick();
        check("burst.rdata", 32'(a_rdata), 32'h77);
        a_wr = 1'b0;
        a_rd = 1'b0;
        tick();
        check("burst.count", 32'(a_count), 1);
        a_wr = 1'b1;
        a_wdata = 8'h79;
        tick();
        a_rd = 1'b1;
        a_rst_n = 1'b0;
        tick();
        check_a_reset("midburst_reset");
        a_rst_n = 1'b1;
        a_wr = 1'b0;
        a_rd = 1'b0;

        // Instance B: depth-10 wrap. Write 10, read 5, then write 5 more.
        b_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_wdata = 8'(i);
            tick();
        end
        check("b_fill.full", 32'(b_full), 1);
        b_wr = 1'b0;
        b_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_read5.rdata", 32'(b_rdata), 32'(i));
        end
        b_rd = 1'b0;
        b_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_wdata = 8'(8'h50 + i);
            tick();
        end
        b_wr = 1'b0;
        check("b_wrap.full", 32'(b_full), 1);
        check("b_wrap.count", 32'(b_count), 10);
        check("b_wrap.ovf", 32'(b_ovf), 0);
        $display("txn b wrap fill: count=%0d full=%0d ovf=%0d", b_count, b_full, b_ovf);
        b_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("b_wrap_read.rdata", 32'(b_rdata), (i < 5) ? 32'(5 + i) : 32'(8'h50 + i - 5));
            check("b_wrap_read.rvalid", 32'(b_rvalid), 1);
            $display("txn b read: rdata=0x%02h", b_rdata);
        end
        b_rd = 1'b0;
        check("b_wrap_read.empty", 32'(b_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised, single-clock circular FIFO. Occupancy-counter based; next generation of the team's 8x16 counter FIFO.
- Adds over the previous generation:
  - configurable width and depth, including non-power-of-2 depth
  - almost-full / almost-empty thresholds and an occupancy output
  - read-data valid strobe and synchronous flush
  - sticky overflow / underflow error flags
- Used as the generic buffering element between producer/consumer stages in the datapath.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 16, number of storage entries (>=2; any integer, not restricted to powers of 2)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- CNT_W, $clog2(DEPTH+1), occupancy width (derived; do not override)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of FIFO contents
- clr_err  in  1  clears overflow/underflow sticky flags
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: rd_data updated this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  CNT_W  current occupancy
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0 at posedge) values:
  - wr_ptr=0, rd_ptr=0, count=0
  - rd_data=0, rd_valid=0, overflow=0, underflow=0
  - hence empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1)
  - Storage array is not reset.
  - Reset overrides every other input, including mid-burst.
- Status flags are combinational decodes of the registered count only; no decode from wr_en/rd_en.
- Read acceptance:
  - rd_acc = rd_en & !empty.
- Write acceptance:
  - wr_acc = wr_en & (!full | rd_acc).
  - A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Pointers, range 0..DEPTH-1:
  - On acceptance, ptr <= (ptr == DEPTH-1) ? 0 : ptr+1.
  - Explicit compare against DEPTH-1; no reliance on natural binary wrap.
- Write: on wr_acc, mem[wr_ptr] <= wr_data.
- Read:
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 (latency 1 cycle from rd_en to rd_valid).
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- Count update:
  - count <= count + wr_acc - rd_acc.
  - Both accepted: count unchanged.
  - count never exceeds DEPTH and never underflows.
- Simultaneous write and read:
  - Empty: write accepted, read rejected (no same-cycle bypass); underflow sets; data readable next cycle.
  - Full with rd_en=1: both accepted, count stays DEPTH; rd_data gets the oldest entry, new word written to the freed slot.
- Error flags:
  - overflow <= 1 on wr_en & !wr_acc.
  - underflow <= 1 on rd_en & empty.
  - Both are cleared only by clr_err or reset.
  - If clr_err coincides with a new error event, the set wins (flag =1).
- Flush (priority below reset, above wr/rd):
  - wr_ptr=rd_ptr=count=0, rd_valid=0.
  - wr_en/rd_en in the same cycle are ignored and do not set error flags.
  - rd_data holds; error flags hold.

Test Plan:
- Reset, then DATA_W=8, DEPTH=16, AF=14, AE=2: write 0x00..0x0F on consecutive cycles.
  - full=1 at count=16; almost_full first asserts after the 14th write.
  - A 17th write (0xAA) sets overflow=1; count stays 16.
- From full, read 16 times:
  - rd_data = 0x00..0x0F in order, each with rd_valid one cycle after rd_en.
  - empty=1 after the last read.
  - A further rd_en sets underflow=1; rd_valid stays 0; rd_data holds 0x0F.
- Wrap-around with DEPTH=10 (non-power-of-2): write 10, read 5, write 5 (0x50..0x54).
  - full=1, count=10, no overflow.
  - Reading 10 returns 0x05..0x09 then 0x50..0x54.
- Full + simultaneous wr_en/rd_en for 20 cycles (wr_data incrementing from 0x80):
  - count stays 16, full stays 1, no overflow.
  - Read stream continues strictly FIFO-ordered across the pointer wrap.
- Empty + simultaneous wr_en(0x33)/rd_en:
  - count=1, underflow=1, rd_valid=0.
  - Next-cycle rd_en returns 0x33.
- With count=7 and overflow=1:
  - Assert flush with wr_en=1, rd_en=1 → count=0, empty=1, overflow still 1, no new write.
  - Then clr_err → overflow=0.
  - Then rst_n=0 mid-burst → all outputs at reset values next cycle.
